ps2_mouse_ctrl: RTL and testbench

- Sequences the PS/2 host transmitter (`ps2_tx`) and receiver (`ps2_rx`) to bring a PS/2 mouse up: reset, self-test check, enable data reporting.
- Then assembles the 3-byte movement packets for the VGA cursor logic.
- Sits between the PS/2 PHY pair and the mouse/VGA application layer. It is the only requester driving `wr_ps2`.

---
 rtl/ps2_pkg.sv | 43 ++++
 rtl/ps2_pkt_asm.sv | 78 +++++++
 rtl/ps2_mouse_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_ps2_mouse_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 mouse controller.
// Holds the mouse command/response byte values, the init FSM state encoding
// and the packet-assembler byte index limit.
package ps2_pkg;

    // Host-to-mouse commands
    localparam logic [7:0] CMD_RESET     = 8'hFF;
    localparam logic [7:0] CMD_EN_REPORT = 8'hF4;

    // Mouse-to-host responses
    localparam logic [7:0] RSP_ACK       = 8'hFA;
    localparam logic [7:0] RSP_RESEND    = 8'hFE;
    localparam logic [7:0] RSP_BAT_OK    = 8'hAA;
    localparam logic [7:0] RSP_BAT_ERR   = 8'hFC;
    localparam logic [7:0] MOUSE_ID      = 8'h00;

    // Init FSM state encoding
    localparam logic [3:0] ST_PWRUP    = 4'd0;
    localparam logic [3:0] ST_SEND     = 4'd1;
    localparam logic [3:0] ST_WAIT_TX  = 4'd2;
    localparam logic [3:0] ST_WAIT_ACK = 4'd3;
    localparam logic [3:0] ST_WAIT_BAT = 4'd4;
    localparam logic [3:0] ST_WAIT_ID  = 4'd5;
    localparam logic [3:0] ST_FAIL     = 4'd6;
    localparam logic [3:0] ST_ERROR    = 4'd7;
    localparam logic [3:0] ST_STREAM   = 4'd8;

    typedef enum logic [3:0] {
        StPwrup   = ST_PWRUP,
        StSend    = ST_SEND,
        StWaitTx  = ST_WAIT_TX,
        StWaitAck = ST_WAIT_ACK,
        StWaitBat = ST_WAIT_BAT,
        StWaitId  = ST_WAIT_ID,
        StFail    = ST_FAIL,
        StError   = ST_ERROR,
        StStream  = ST_STREAM
    } state_t;

    // Index of the last byte of a 3-byte movement packet
    localparam logic [1:0] PKT_LAST_IDX = 2'd2;

endpackage

// File: rtl/ps2_pkt_asm.sv
// Three-byte PS/2 mouse movement packet assembler.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_en                  assemble only while the mouse is streaming
//   i_rx_done_tick        received byte valid pulse
//   i_rx_data             received byte
//   o_pkt_valid           one-cycle pulse when a full packet is in o_pkt_data
//   o_pkt_data            {byte2, byte1, byte0}
// Byte 0 must have bit 3 set; a packet left incomplete for TIMEOUT_CYC cycles
// is abandoned and assembly restarts at byte 0.
module ps2_pkt_asm
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 2_500_000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    input  logic        i_rx_done_tick,
    input  logic [7:0]  i_rx_data,
    output logic        o_pkt_valid,
    output logic [23:0] o_pkt_data
);

    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);

    logic [1:0]  r_idx;
    logic [31:0] r_timer;
    logic        r_pkt_valid;
    logic [23:0] r_pkt_data;

    logic w_accept;
    logic w_resync;

    // A byte at index 0 without the sync bit is discarded outright
    assign w_accept = i_en && i_rx_done_tick && ((r_idx != 2'd0) || i_rx_data[3]);
    // A byte arriving on the timeout cycle takes priority over the resync
    assign w_resync = i_en && (r_idx != 2'd0) && (r_timer == TO_LAST) && !w_accept;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_idx       <= 2'd0;
            r_timer     <= 32'd0;
            r_pkt_valid <= 1'b0;
            r_pkt_data  <= 24'd0;
        end else begin
            r_pkt_valid <= 1'b0;
            if (!i_en) begin
                r_idx   <= 2'd0;
                r_timer <= 32'd0;
            end else if (w_accept) begin
                r_timer <= 32'd0;
                case (r_idx)
                    2'd0:    r_pkt_data[7:0]   <= i_rx_data;
                    2'd1:    r_pkt_data[15:8]  <= i_rx_data;
                    default: r_pkt_data[23:16] <= i_rx_data;
                endcase
                if (r_idx == PKT_LAST_IDX) begin
                    r_idx       <= 2'd0;
                    r_pkt_valid <= 1'b1;
                end else begin
                    r_idx <= r_idx + 2'd1;
                end
            end else if (w_resync) begin
                r_idx   <= 2'd0;
                r_timer <= 32'd0;
            end else if (r_idx != 2'd0) begin
                r_timer <= r_timer + 32'd1;
            end else begin
                r_timer <= 32'd0;
            end
        end
    end

    assign o_pkt_valid = r_pkt_valid;
    assign o_pkt_data  = r_pkt_data;

endmodule

// File: rtl/ps2_mouse_ctrl.sv
// PS/2 mouse bring-up sequencer and packet front end.
// Ports:
//   i_clk, i_rst                clock, synchronous active-high reset
//   i_tx_idle, i_tx_done_tick   PS/2 transmitter status
//   o_wr_ps2, o_tx_data         one-cycle transmit request and command byte
//   i_rx_done_tick, i_rx_data   PS/2 receiver byte stream
//   o_rx_en                     receiver enable
//   o_pkt_valid, o_pkt_data     assembled 3-byte movement packet
//   o_init_done                 mouse is streaming
//   o_init_err                  sticky init failure (retries exhausted)
// Sequence: power-up wait, reset (FF) with ACK/BAT/ID check, enable reporting
// (F4) with ACK, then stream packets. Any failure restarts from FF until
// MAX_RETRY attempts have been used.
module ps2_mouse_ctrl
    import ps2_pkg::*;
#(
    parameter int unsigned POWERUP_CYC = 25_000_000,
    parameter int unsigned TIMEOUT_CYC = 2_500_000,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_tx_idle,
    input  logic        i_tx_done_tick,
    output logic        o_wr_ps2,
    output logic [7:0]  o_tx_data,
    input  logic        i_rx_done_tick,
    input  logic [7:0]  i_rx_data,
    output logic        o_rx_en,
    output logic        o_pkt_valid,
    output logic [23:0] o_pkt_data,
    output logic        o_init_done,
    output logic        o_init_err
);

    localparam logic [31:0] PWR_LAST  = 32'(POWERUP_CYC - 1);
    localparam logic [31:0] TO_LAST   = 32'(TIMEOUT_CYC - 1);
    localparam logic [31:0] BAT_LAST  = 32'(20 * TIMEOUT_CYC - 1);
    localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRY);

    state_t      r_state;
    logic [31:0] r_timer;
    logic [7:0]  r_cmd;
    logic [7:0]  r_retry;
    logic        r_wr_ps2;
    logic [7:0]  r_tx_data;
    logic        r_rx_en;
    logic        r_init_done;
    logic        r_init_err;

    state_t      w_state_d;
    logic [31:0] w_timer_d;
    logic [7:0]  w_cmd_d;
    logic [7:0]  w_retry_d;
    logic        w_wr_d;
    logic [7:0]  w_tx_data_d;
    logic [31:0] w_limit;
    logic        w_timeout;
    logic        w_byte_acc;
    logic        w_counting;
    logic [7:0]  w_retry_inc;

    assign w_retry_inc = r_retry + 8'd1;
    assign w_timeout   = (r_timer == w_limit);

    always_comb begin
        w_limit = TO_LAST;
        case (r_state)
            StPwrup:   w_limit = PWR_LAST;
            StWaitBat: w_limit = BAT_LAST;
            default:   w_limit = TO_LAST;
        endcase
    end

    always_comb begin
        w_state_d   = r_state;
        w_cmd_d     = r_cmd;
        w_retry_d   = r_retry;
        w_wr_d      = 1'b0;
        w_tx_data_d = r_tx_data;
        w_byte_acc  = 1'b0;

        case (r_state)
            StPwrup: begin
                if (w_timeout) begin
                    w_cmd_d   = CMD_RESET;
                    w_state_d = StSend;
                end
            end
            StSend: begin
                if (i_tx_idle) begin
                    w_wr_d      = 1'b1;
                    w_tx_data_d = r_cmd;
                    w_state_d   = StWaitTx;
                end
            end
            StWaitTx: begin
                if (i_tx_done_tick) begin
                    w_state_d = StWaitAck;
                end else if (w_timeout) begin
                    w_state_d = StFail;
                end
            end
            StWaitAck: begin
                if (i_rx_done_tick) begin
                    w_byte_acc = 1'b1;
                    if (i_rx_data == RSP_ACK) begin
                        w_state_d = (r_cmd == CMD_RESET) ? StWaitBat : StStream;
                    end else if (i_rx_data == RSP_RESEND) begin
                        // A resend costs one attempt, same as a failure
                        w_retry_d = w_retry_inc;
                        w_state_d = (w_retry_inc == RETRY_MAX) ? StError : StSend;
                    end else begin
                        w_state_d = StFail;
                    end
                end else if (w_timeout) begin
                    w_state_d = StFail;
                end
            end
            StWaitBat: begin
                if (i_rx_done_tick) begin
                    w_byte_acc = 1'b1;
                    w_state_d  = (i_rx_data == RSP_BAT_OK) ? StWaitId : StFail;
                end else if (w_timeout) begin
                    w_state_d = StFail;
                end
            end
            StWaitId: begin
                if (i_rx_done_tick) begin
                    w_byte_acc = 1'b1;
                    if (i_rx_data == MOUSE_ID) begin
                        w_cmd_d   = CMD_EN_REPORT;
                        w_state_d = StSend;
                    end else begin
                        w_state_d = StFail;
                    end
                end else if (w_timeout) begin
                    w_state_d = StFail;
                end
            end
            StFail: begin
                w_retry_d = w_retry_inc;
                if (w_retry_inc == RETRY_MAX) begin
                    w_state_d = StError;
                end else begin
                    w_cmd_d   = CMD_RESET;
                    w_state_d = StSend;
                end
            end
            StError:  w_state_d = StError;
            StStream: w_state_d = StStream;
            default:  w_state_d = StPwrup;
        endcase

        // Timer only runs in states with a deadline and restarts on any progress
        w_counting = r_state inside {StPwrup, StWaitTx, StWaitAck, StWaitBat, StWaitId};
        if ((w_state_d != r_state) || w_byte_acc || !w_counting) begin
            w_timer_d = 32'd0;
        end else begin
            w_timer_d = r_timer + 32'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StPwrup;
            r_timer     <= 32'd0;
            r_cmd       <= 8'h00;
            r_retry     <= 8'd0;
            r_wr_ps2    <= 1'b0;
            r_tx_data   <= 8'h00;
            r_rx_en     <= 1'b0;
            r_init_done <= 1'b0;
            r_init_err  <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_timer     <= w_timer_d;
            r_cmd       <= w_cmd_d;
            r_retry     <= w_retry_d;
            r_wr_ps2    <= w_wr_d;
            r_tx_data   <= w_tx_data_d;
            // Flags follow the state being entered so they line up with r_state
            r_rx_en     <= !(w_state_d inside {StSend, StWaitTx, StError});
            r_init_done <= (w_state_d == StStream);
            r_init_err  <= (w_state_d == StError);
        end
    end

    ps2_pkt_asm #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_pkt_asm (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_en           (r_init_done),
        .i_rx_done_tick (i_rx_done_tick),
        .i_rx_data      (i_rx_data),
        .o_pkt_valid    (o_pkt_valid),
        .o_pkt_data     (o_pkt_data)
    );

    assign o_wr_ps2    = r_wr_ps2;
    assign o_tx_data   = r_tx_data;
    assign o_rx_en     = r_rx_en;
    assign o_init_done = r_init_done;
    assign o_init_err  = r_init_err;

endmodule

// File: tb/tb_ps2_mouse_ctrl.sv
// Self-checking bench for ps2_mouse_ctrl: plays the role of the PS/2 PHY pair
// and the mouse, and checks commands, init status and assembled packets.
module tb_ps2_mouse_ctrl;

    localparam int unsigned PWR = 100;
    localparam int unsigned TO  = 1000;
    localparam int unsigned MR  = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tx_idle = 1'b1;
    logic        tx_done_tick = 1'b0;
    logic        rx_done_tick = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        wr_ps2;
    logic [7:0]  tx_data;
    logic        rx_en;
    logic        pkt_valid;
    logic [23:0] pkt_data;
    logic        init_done;
    logic        init_err;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_wr   = 0;
    int n_wr_double = 0;
    int n_pv_double = 0;
    logic prev_wr = 1'b0;
    logic prev_pv = 1'b0;
    logic [23:0] q_pkt[$];
    logic [23:0] q_exp[$];
    logic [7:0]  part[$];

    ps2_mouse_ctrl #(
        .POWERUP_CYC (PWR),
        .TIMEOUT_CYC (TO),
        .MAX_RETRY   (MR)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_tx_idle      (tx_idle),
        .i_tx_done_tick (tx_done_tick),
        .o_wr_ps2       (wr_ps2),
        .o_tx_data      (tx_data),
        .i_rx_done_tick (rx_done_tick),
        .i_rx_data      (rx_data),
        .o_rx_en        (rx_en),
        .o_pkt_valid    (pkt_valid),
        .o_pkt_data     (pkt_data),
        .o_init_done    (init_done),
        .o_init_err     (init_err)
    );

    always #5 clk = ~clk;

    // Passive monitor: counts transmit requests, collects packets
    always @(negedge clk) begin
        if (wr_ps2) n_wr++;
        if (wr_ps2 && prev_wr) n_wr_double++;
        if (pkt_valid && prev_pv) n_pv_double++;
        if (pkt_valid) q_pkt.push_back(pkt_data);
        prev_wr = wr_ps2;
        prev_pv = pkt_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " wr_ps2"}, 32'(wr_ps2), 32'd0);
        check({tag, " tx_data"}, 32'(tx_data), 32'h00);
        check({tag, " rx_en"}, 32'(rx_en), 32'd0);
        check({tag, " pkt_valid"}, 32'(pkt_valid), 32'd0);
        check({tag, " pkt_data"}, 32'(pkt_data), 32'h0);
        check({tag, " init_done"}, 32'(init_done), 32'd0);
        check({tag, " init_err"}, 32'(init_err), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        tx_idle = 1'b1;
        tx_done_tick = 1'b0;
        rx_done_tick = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Wait for a transmit request; returns the byte and the cycles waited
    task automatic wait_cmd(input int budget, output logic [7:0] b, output bit ok,
                            output int waited);
        ok = 1'b0;
        b = 8'h00;
        waited = 0;
        while (!ok && waited < budget) begin
            @(negedge clk);
            waited++;
            if (wr_ps2) begin
                b = tx_data;
                ok = 1'b1;
            end
        end
    endtask

    // Transmitter model: busy for a few cycles, then byte-complete pulse
    task automatic complete_tx();
        tx_idle = 1'b0;
        repeat (3) @(negedge clk);
        tx_done_tick = 1'b1;
        @(negedge clk);
        tx_done_tick = 1'b0;
        tx_idle = 1'b1;
    endtask

    task automatic expect_cmd(input string tag, input logic [7:0] exp);
        logic [7:0] b;
        bit ok;
        int waited;
        wait_cmd(3000, b, ok, waited);
        check({tag, " seen"}, 32'(ok), 32'd1);
        check(tag, 32'(b), 32'(exp));
        if (ok) complete_tx();
    endtask

    task automatic send_rx(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge clk);
        rx_data = b;
        rx_done_tick = 1'b1;
        @(negedge clk);
        rx_done_tick = 1'b0;
    endtask

    task automatic wait_flag(input bit want_err, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (want_err ? init_err : init_done) ok = 1'b1;
        end
    endtask

    // Mouse model for a clean bring-up after the first FF has been seen
    task automatic finish_init(input string tag);
        bit ok;
        send_rx(8'hFA, $urandom_range(1, 40));
        send_rx(8'hAA, $urandom_range(1, 40));
        send_rx(8'h00, $urandom_range(1, 40));
        expect_cmd({tag, " cmd F4"}, 8'hF4);
        send_rx(8'hFA, $urandom_range(1, 40));
        wait_flag(1'b0, 20, ok);
        check({tag, " init_done"}, 32'(init_done), 32'd1);
        check({tag, " init_err"}, 32'(init_err), 32'd0);
        check({tag, " rx_en"}, 32'(rx_en), 32'd1);
    endtask

    // Reference packet model: bytes gathered into a list, byte 0 needs bit 3
    task automatic stream_byte(input logic [7:0] b, input int gap);
        if (!(part.size() == 0 && !b[3])) begin
            part.push_back(b);
            if (part.size() == 3) begin
                q_exp.push_back({part[2], part[1], part[0]});
                part.delete();
            end
        end
        send_rx(b, gap);
    endtask

    task automatic stream_idle(input int n);
        repeat (n) @(negedge clk);
        if (n >= int'(TO)) part.delete();
    endtask

    initial begin
        logic [7:0] b;
        bit ok;
        int waited;
        int n0;

        // ---- Reset values ----
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // ---- Nominal init ----
        wait_cmd(400, b, ok, waited);
        check("pwrup first cmd seen", 32'(ok), 32'd1);
        check("pwrup latency", 32'(waited >= int'(PWR) && waited <= int'(PWR) + 3), 32'd1);
        check("nominal cmd FF", 32'(b), 32'hFF);
        check("rx_en low while sending", 32'(rx_en), 32'd0);
        if (ok) complete_tx();
        finish_init("nominal");
        check("nominal wr count", 32'(n_wr), 32'd2);

        // ---- Packets in STREAM ----
        q_pkt.delete();
        stream_byte(8'h00, 3);
        stream_byte(8'h08, 2);
        stream_byte(8'h05, 2);
        stream_byte(8'hFB, 2);
        stream_byte(8'h08, 5);
        stream_byte(8'h05, 5);
        stream_idle(TO + 10);
        stream_byte(8'h09, 0);
        stream_byte(8'h01, 3);
        stream_byte(8'h02, 3);
        stream_byte(8'h18, 3);
        stream_idle(TO - 10);
        stream_byte(8'h77, 0);
        stream_byte(8'h66, 0);
        for (int p = 0; p < 20; p++) begin
            int nb;
            if ($urandom_range(0, 2) == 0) stream_byte(8'($urandom) & 8'hF7, $urandom_range(0, 30));
            nb = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 2) : 3;
            stream_byte(8'($urandom) | 8'h08, $urandom_range(0, 30));
            for (int k = 1; k < nb; k++) stream_byte(8'($urandom), $urandom_range(0, 30));
            if (nb < 3) stream_idle(TO + $urandom_range(5, 40));
        end
        repeat (10) @(negedge clk);
        check("pkt count", 32'(q_pkt.size()), 32'(q_exp.size()));
        if (q_exp.size() >= 3) begin
            check("pkt directed 0", 32'(q_exp[0]), 32'hFB0508);
            check("pkt directed 1", 32'(q_exp[1]), 32'h020109);
        end
        for (int i = 0; i < q_pkt.size() && i < q_exp.size(); i++) begin
            check($sformatf("pkt %0d", i), 32'(q_pkt[i]), 32'(q_exp[i]));
        end
        check("pkt_valid single cycle", 32'(n_pv_double), 32'd0);
        check("no wr in stream", 32'(n_wr), 32'd2);

        // ---- Reset during WAIT_TX ----
        do_reset();
        wait_cmd(400, b, ok, waited);
        check("rst-mid cmd FF", 32'(b), 32'hFF);
        tx_idle = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst-mid");
        rst = 1'b0;
        tx_idle = 1'b1;
        wait_cmd(400, b, ok, waited);
        check("rst-mid full pwrup", 32'(waited >= int'(PWR) && waited <= int'(PWR) + 3), 32'd1);
        check("rst-mid restart FF", 32'(b), 32'hFF);
        if (ok) complete_tx();

        // ---- Resend, with transmitter held busy ----
        n0 = n_wr;
        tx_idle = 1'b0;
        send_rx(8'hFE, 5);
        repeat (200) @(negedge clk);
        check("no wr while tx busy", 32'(n_wr - n0), 32'd0);
        tx_idle = 1'b1;
        expect_cmd("resend FF again", 8'hFF);
        finish_init("resend");
        check("resend wr count", 32'(n_wr - n0), 32'd2);

        // ---- Silent device ----
        do_reset();
        n0 = n_wr;
        for (int a = 0; a < int'(MR); a++) begin
            expect_cmd($sformatf("silent FF %0d", a), 8'hFF);
            if (a == 1) check("silent no err yet", 32'(init_err), 32'd0);
        end
        wait_flag(1'b1, 1500, ok);
        check("silent init_err", 32'(init_err), 32'd1);
        check("silent rx_en", 32'(rx_en), 32'd0);
        check("silent init_done", 32'(init_done), 32'd0);
        repeat (3000) @(negedge clk);
        check("silent wr count", 32'(n_wr - n0), 32'(MR));

        // ---- BAT failure ----
        do_reset();
        n0 = n_wr;
        for (int a = 0; a < int'(MR); a++) begin
            expect_cmd($sformatf("bat FF %0d", a), 8'hFF);
            send_rx(8'hFA, $urandom_range(1, 40));
            send_rx(8'hFC, $urandom_range(1, 40));
        end
        wait_flag(1'b1, 50, ok);
        check("bat init_err", 32'(init_err), 32'd1);
        check("bat rx_en", 32'(rx_en), 32'd0);
        repeat (500) @(negedge clk);
        check("bat wr count", 32'(n_wr - n0), 32'(MR));
        check("wr_ps2 single cycle", 32'(n_wr_double), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
